// File: rtl/i2c_mon_pkg.sv
`default_nettype none
// ============================================================================
// i2c_mon_pkg : shared FSM state encoding and bit-counter width
// Rev 1.0
// ============================================================================
package i2c_mon_pkg;

   localparam int BIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BITS = 2'd1,
      ACK  = 2'd2
   } mon_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// i2c_line_filter : tick-enabled history filter with all-ones/all-zeros hysteresis
// Rev 1.0
// ============================================================================
module i2c_line_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic filt,
   output logic filt_next
);

   logic [FILT_LEN-1:0] hist_q, hist_d;
   logic                filt_q, filt_d;

   always_comb begin
      hist_d = hist_q;
      filt_d = filt_q;
      if (tick) begin
         hist_d = {hist_q[FILT_LEN-2:0], raw};
         if (&hist_d) begin
            filt_d = 1'b1;
         end else if (~|hist_d) begin
            filt_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '1;
         filt_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   // filt_next lets the parent see the level this tick commits, for edge detection
   assign filt      = filt_q;
   assign filt_next = filt_d;

endmodule
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// i2c_bus_monitor : passive I2C monitor - line filters, START/STOP, byte capture
// Optional SCL-timeout abort enabled by macro I2C_MON_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module i2c_bus_monitor
   import i2c_mon_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int FILT_LEN      = 4,
   parameter int TIMEOUT_TICKS = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic [7:0] byte_data,
   output logic       byte_ack,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       start_det,
   output logic       stop_det,
   output logic       bus_busy,
   output logic       overrun,
   input  logic       clr_overrun,
   output logic       timeout
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0]     div_q, div_d;
   logic                 tick;
   logic                 scl_f, sda_f, scl_nx, sda_nx;
   logic                 scl_rise, scl_edge, start_ev, stop_ev, to_hit;
   mon_state_e           state_q, state_d;
   logic [BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [7:0]           shift_q, shift_d, byte_data_q, byte_data_d;
   logic                 byte_ack_q, byte_ack_d, byte_valid_q, byte_valid_d;
   logic                 bus_busy_q, bus_busy_d, overrun_q, overrun_d;
   logic                 start_det_q, start_det_d, stop_det_q, stop_det_d;
   logic                 timeout_q, timeout_d, byte_done, ack_bit, ovr_set;

   assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(clk), .rst(rst), .tick(tick), .raw(scl_in), .filt(scl_f), .filt_next(scl_nx)
   );
   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(clk), .rst(rst), .tick(tick), .raw(sda_in), .filt(sda_f), .filt_next(sda_nx)
   );

   // An SCL edge on the same tick masks any SDA transition as START/STOP
   assign scl_rise = tick & scl_nx & ~scl_f;
   assign scl_edge = tick & (scl_nx ^ scl_f);
   assign start_ev = tick & ~scl_edge & scl_f & sda_f & ~sda_nx;
   assign stop_ev  = tick & ~scl_edge & scl_f & ~sda_f & sda_nx;

`ifdef I2C_MON_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (!bus_busy_q || scl_edge) begin
         to_cnt_d = '0;
      end else if (tick) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   assign to_hit = tick & bus_busy_q & ~scl_edge & (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_TICKS != 0);
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      bus_busy_d  = bus_busy_q;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      timeout_d   = 1'b0;
      byte_done   = 1'b0;
      ack_bit     = 1'b0;
      if (stop_ev) begin
         stop_det_d = 1'b1;
         state_d    = IDLE;
         bus_busy_d = 1'b0;
         bitcnt_d   = '0;
         shift_d    = '0;
      end else if (start_ev) begin
         start_det_d = 1'b1;
         state_d     = BITS;
         bus_busy_d  = 1'b1;
         bitcnt_d    = '0;
         shift_d     = '0;
      end else if (to_hit) begin
         timeout_d  = 1'b1;
         state_d    = IDLE;
         bus_busy_d = 1'b0;
         bitcnt_d   = '0;
         shift_d    = '0;
      end else if (scl_rise) begin
         case (state_q)
            BITS: begin
               shift_d  = {shift_q[6:0], sda_nx};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == BIT_CNT_W'(7)) state_d = ACK;
            end
            ACK: begin
               byte_done = 1'b1;
               ack_bit   = ~sda_nx;
               state_d   = BITS;
               bitcnt_d  = '0;
            end
            default: ;
         endcase
      end
   end

   // Holding register: a new byte loads only if the slot is free or emptying now
   always_comb begin
      byte_data_d  = byte_data_q;
      byte_ack_d   = byte_ack_q;
      byte_valid_d = byte_valid_q;
      ovr_set      = 1'b0;
      if (byte_done && (!byte_valid_q || byte_ready)) begin
         byte_data_d  = shift_q;
         byte_ack_d   = ack_bit;
         byte_valid_d = 1'b1;
      end else begin
         ovr_set = byte_done;
         if (byte_valid_q && byte_ready) byte_valid_d = 1'b0;
      end
      overrun_d = ovr_set | (overrun_q & ~clr_overrun);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q        <= '0;
         state_q      <= IDLE;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         bus_busy_q   <= 1'b0;
         start_det_q  <= 1'b0;
         stop_det_q   <= 1'b0;
         timeout_q    <= 1'b0;
         byte_data_q  <= '0;
         byte_ack_q   <= 1'b0;
         byte_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         div_q        <= div_d;
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         shift_q      <= shift_d;
         bus_busy_q   <= bus_busy_d;
         start_det_q  <= start_det_d;
         stop_det_q   <= stop_det_d;
         timeout_q    <= timeout_d;
         byte_data_q  <= byte_data_d;
         byte_ack_q   <= byte_ack_d;
         byte_valid_q <= byte_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign byte_data  = byte_data_q;
   assign byte_ack   = byte_ack_q;
   assign byte_valid = byte_valid_q;
   assign start_det  = start_det_q;
   assign stop_det   = stop_det_q;
   assign bus_busy   = bus_busy_q;
   assign overrun    = overrun_q;
   assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Passive I2C bus monitor that sequences the line-conditioning datapath. It generates the sample strobe and drives two hysteresis filters, one each for SCL and SDA. From the filtered lines it detects START/STOP and assembles each 8-bit transfer plus its ACK bit. It sits between the raw pad inputs and any protocol-level consumer, and hands out one byte per valid/ready handshake.

## Interface
- CLK_DIV, 4: clk cycles per sample tick (>=1)
- FILT_LEN, 4: filter history depth in sample ticks (>=2)
- TIMEOUT_TICKS, 1024: sample ticks without an SCL edge before abort (only with I2C_MON_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- scl_in  in  1  raw SCL, already synchronised
- sda_in  in  1  raw SDA, already synchronised
- byte_data  out  8  captured byte, MSB first on the wire
- byte_ack  out  1  1 = ACK (SDA low on 9th bit)
- byte_valid  out  1  byte_data/byte_ack valid
- byte_ready  in  1  consumer accepts
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP
- bus_busy  out  1  high from START until STOP or abort
- overrun  out  1  sticky, a completed byte was dropped
- clr_overrun  in  1  clears overrun
- timeout  out  1  one-cycle pulse on SCL timeout abort

## Operation
- Tick counter counts 0..CLK_DIV-1 and asserts tick on wrap. Filters advance only on tick.
- Filter: shift the raw bit into a FILT_LEN-bit history. Output goes to 1 when the history is all ones and to 0 when it is all zeros. Otherwise the output holds.
- Edge detection compares the filtered values against their previous-tick copies.
- START: SDA falls while SCL=1. STOP: SDA rises while SCL=1. If both lines change on the same tick, the SCL edge takes priority and no START/STOP is flagged.
- FSM states are IDLE, BITS and ACK.
  - IDLE: START -> BITS, bitcnt=0, bus_busy=1.
  - BITS: each SCL rise shifts SDA into the shift register. After the 8th rise -> ACK.
  - ACK: the next SCL rise latches ack = !SDA, completes the byte -> BITS, bitcnt=0.
- Repeated START in BITS/ACK: discard the partial byte, pulse start_det, go to BITS with bitcnt=0.
- STOP in any state: discard the partial byte, pulse stop_det, go to IDLE, bus_busy=0.
- STOP or START in IDLE only pulses its detector. START in IDLE also sets bus_busy.
- Output handshake on byte completion:
  - If byte_valid=0, or byte_valid=1 with byte_ready=1 in the same cycle: load byte_data/byte_ack and set byte_valid.
  - Otherwise drop the new byte, keep the held byte and set overrun.
- byte_valid falls on the cycle after byte_ready=1 while valid, unless a new byte loads in that same cycle.
- clr_overrun clears overrun. A simultaneous set wins.

## Timing
- Reset values:
  - Filter histories all ones; filtered SCL=SDA=1.
  - Tick counter 0, FSM IDLE, bitcnt 0, shift register 0.
  - byte_data=0x00, byte_ack=0, byte_valid=0.
  - start_det=0, stop_det=0, bus_busy=0, overrun=0, timeout=0.
- Filter latency: a stable level propagates after FILT_LEN ticks, i.e. FILT_LEN*CLK_DIV clk cycles. Shorter glitches are rejected.
- start_det/stop_det/timeout pulse in the clk cycle after the qualifying tick.
- byte_valid rises one clk cycle after the tick on which the ACK-bit SCL rise is filtered.
- Asserting rst mid-transfer aborts immediately. Any held byte is lost.

## Configuration
- I2C_MON_TIMEOUT_EN defined:
  - A tick counter runs while bus_busy and resets on every filtered SCL edge.
  - When it reaches TIMEOUT_TICKS: discard the partial byte, go to IDLE, clear bus_busy, pulse timeout.
- Undefined: no counter, and timeout is tied to 0.

## Structure
- Package i2c_mon_pkg holds the FSM state enum (IDLE, BITS, ACK) and the bit-count width constant.
- One sub-module, i2c_line_filter, contains the FILT_LEN history and hysteresis output with tick enable. It is instantiated twice, once for SCL and once for SDA.

## Test plan
- Reset, idle lines high for 100 cycles -> all outputs 0, bus_busy=0.
- 1-tick low glitch on sda_in while SCL high (FILT_LEN=4) -> no start_det, filtered SDA stays 1.
- START, byte 0xA5, ACK low, STOP -> start_det pulse, byte_data=0xA5, byte_ack=1, byte_valid until ready, stop_det pulse, bus_busy=0.
- Two bytes 0x3C then 0xC3 with byte_ready held 0 -> byte_data stays 0x3C, overrun=1; clr_overrun -> overrun=0.
- Repeated START after 5 bits, then byte 0x81 NACK -> no byte from the partial, then byte_data=0x81, byte_ack=0.
- With I2C_MON_TIMEOUT_EN and TIMEOUT_TICKS=16: START, then SCL held low for 20 ticks -> timeout pulse, bus_busy=0, FSM IDLE.
